// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared widths, response codes and channel state types for the AXI-Lite slave
package axi_lite_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE    = 2'b00,
        W_COLLECT = 2'b01,
        W_RESP    = 2'b10
    } write_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } read_state_t;

endpackage

// File: rtl/axi_lite_slave_if.sv
// rtl/axi_lite_slave_if.sv - AXI-Lite channel bundle with master and slave views
interface axi_lite_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] aw_addr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] w_data;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] ar_addr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        rresp;

    modport master (
        output awvalid, aw_addr, wvalid, w_data, bready, arvalid, ar_addr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, r_data, rresp
    );

    modport slave (
        input  awvalid, aw_addr, wvalid, w_data, bready, arvalid, ar_addr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, r_data, rresp
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - register array, one write port, one asynchronous read port, reset to zero
module axi_lite_regfile #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads see the pre-edge contents, so a same-edge write never leaks into a read.
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/axi_lite_slave.sv
// rtl/axi_lite_slave.sv - AXI4-Lite register-bank slave with independent write and read channel FSMs
module axi_lite_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = AXIL_ADDR_W,
    parameter int DATA_W = AXIL_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] w_data,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] ar_addr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        rresp
);
    localparam int IDX_W = $clog2(DEPTH);

    write_state_t      w_state_q, w_state_d;
    logic              aw_cap_q, aw_cap_d;
    logic              w_cap_q, w_cap_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    read_state_t       r_state_q, r_state_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;

    logic              rf_we;
    logic [IDX_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    logic [IDX_W-1:0]  aw_addr_idx;
    logic [IDX_W-1:0]  ar_addr_idx;
    logic              aw_hs;
    logic              w_hs;
    logic              unused_addr_bits;

    // Word addressing: byte offset dropped, upper bits alias onto the bank.
    assign aw_addr_idx      = aw_addr[2 +: IDX_W];
    assign ar_addr_idx      = ar_addr[2 +: IDX_W];
    assign unused_addr_bits = ^{aw_addr[ADDR_W-1:IDX_W+2], aw_addr[1:0],
                                ar_addr[ADDR_W-1:IDX_W+2], ar_addr[1:0]};

    assign bvalid  = (w_state_q == W_RESP);
    assign awready = !aw_cap_q && !bvalid;
    assign wready  = !w_cap_q && !bvalid;
    assign bresp   = OKAY;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        w_state_d = w_state_q;
        aw_cap_d  = aw_cap_q;
        w_cap_d   = w_cap_q;
        aw_idx_d  = aw_idx_q;
        w_data_d  = w_data_q;
        rf_we     = 1'b0;
        rf_waddr  = aw_cap_q ? aw_idx_q : aw_addr_idx;
        rf_wdata  = w_cap_q ? w_data_q : w_data;
        unique case (w_state_q)
            W_IDLE, W_COLLECT: begin
                if (aw_hs) begin
                    aw_idx_d = aw_addr_idx;
                    aw_cap_d = 1'b1;
                end
                if (w_hs) begin
                    w_data_d = w_data;
                    w_cap_d  = 1'b1;
                end
                // Commit as soon as both halves are held, whichever order they came in.
                if (aw_cap_d && w_cap_d) begin
                    rf_we     = 1'b1;
                    aw_cap_d  = 1'b0;
                    w_cap_d   = 1'b0;
                    w_state_d = W_RESP;
                end else if (aw_cap_d || w_cap_d) begin
                    w_state_d = W_COLLECT;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign rvalid  = (r_state_q == R_DATA);
    assign arready = !rvalid;
    assign r_data  = r_data_q;
    assign rresp   = OKAY;

    always_comb begin
        r_state_d = r_state_q;
        r_data_d  = r_data_q;
        if (r_state_q == R_IDLE) begin
            if (arvalid) begin
                r_data_d  = rf_rdata;
                r_state_d = R_DATA;
            end
        end else if (rready) begin
            r_state_d = R_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            r_state_q <= R_IDLE;
            r_data_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_cap_q  <= aw_cap_d;
            w_cap_q   <= w_cap_d;
            aw_idx_q  <= aw_idx_d;
            w_data_q  <= w_data_d;
            r_state_q <= r_state_d;
            r_data_q  <= r_data_d;
        end
    end

    axi_lite_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .raddr (ar_addr_idx),
        .rdata (rf_rdata)
    );
endmodule

// File: tb/tb_axi_lite_slave.sv
// tb/tb_axi_lite_slave.sv - self-checking bench for axi_lite_slave against a word-array reference model
module tb_axi_lite_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(16)) dut (
        .clk     (clk),
        .rst     (rst_n),
        .awvalid (bus.awvalid),
        .awready (bus.awready),
        .aw_addr (bus.aw_addr),
        .wvalid  (bus.wvalid),
        .wready  (bus.wready),
        .w_data  (bus.w_data),
        .bvalid  (bus.bvalid),
        .bready  (bus.bready),
        .bresp   (bus.bresp),
        .arvalid (bus.arvalid),
        .arready (bus.arready),
        .ar_addr (bus.ar_addr),
        .rvalid  (bus.rvalid),
        .rready  (bus.rready),
        .r_data  (bus.r_data),
        .rresp   (bus.rresp)
    );

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 32'(bus.awready), 32'd1);
        check({tag, "_wready"}, 32'(bus.wready), 32'd1);
        check({tag, "_arready"}, 32'(bus.arready), 32'd1);
        check({tag, "_bvalid"}, 32'(bus.bvalid), 32'd0);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        check({tag, "_bresp"}, 32'(bus.bresp), 32'd0);
        check({tag, "_rresp"}, 32'(bus.rresp), 32'd0);
        check({tag, "_r_data"}, bus.r_data, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int aw_dly, input int w_dly, input int b_dly);
        int cyc = 0;
        bit aw_done = 0;
        bit w_done = 0;
        bit expired = 0;
        while (!(aw_done && w_done) && !expired) begin
            bus.aw_addr = a;
            bus.w_data  = d;
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) w_done = 1;
            step();
            cyc++;
            if (cyc > 40) expired = 1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (expired) begin
            timeout("write_handshake");
            return;
        end
        model[widx(a)] = d;
        check("bvalid_after_commit", 32'(bus.bvalid), 32'd1);
        check("bresp", 32'(bus.bresp), 32'd0);
        for (int i = 0; i < b_dly; i++) begin
            step();
            check("bvalid_held", 32'(bus.bvalid), 32'd1);
            check("awready_blocked", 32'(bus.awready), 32'd0);
            check("wready_blocked", 32'(bus.wready), 32'd0);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("bvalid_cleared", 32'(bus.bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, input int r_dly);
        int cyc = 0;
        d = 'x;
        bus.ar_addr = a;
        bus.arvalid = 1'b1;
        while (!bus.arready && cyc < 40) begin
            step();
            cyc++;
        end
        if (!bus.arready) begin
            bus.arvalid = 1'b0;
            timeout("read_handshake");
            return;
        end
        step();
        bus.arvalid = 1'b0;
        check("rvalid_latency", 32'(bus.rvalid), 32'd1);
        check("rresp", 32'(bus.rresp), 32'd0);
        d = bus.r_data;
        for (int i = 0; i < r_dly; i++) begin
            step();
            check("rvalid_held", 32'(bus.rvalid), 32'd1);
            check("r_data_stable", bus.r_data, d);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check("rvalid_cleared", 32'(bus.rvalid), 32'd0);
        check("arready_restored", 32'(bus.arready), 32'd1);
        check("r_data_retained", bus.r_data, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [31:0] rd;
        logic [31:0] ra;
        logic [31:0] wd;

        bus.awvalid = 0; bus.aw_addr = 0; bus.wvalid = 0; bus.w_data = 0; bus.bready = 0;
        bus.arvalid = 0; bus.ar_addr = 0; bus.rready = 0;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;

        tbl[0] = '{32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_0040, 32'hA5A5_A5A5};
        tbl[1] = '{32'h0000_0007, 32'h0102_0304, 32'h0000_0004, 32'h0102_0304};
        tbl[2] = '{32'h0000_003C, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'hDEAD_BEEF};
        tbl[3] = '{32'h1000_0010, 32'h0000_0005, 32'h0000_0010, 32'h0000_0005};
        tbl[4] = '{32'h0000_0024, 32'hFFFF_FFFF, 32'h0000_0027, 32'hFFFF_FFFF};
        tbl[5] = '{32'h0000_0040, 32'h0BAD_F00D, 32'h0000_0000, 32'h0BAD_F00D};

        repeat (3) step();
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        step();
        check_reset_outputs("idle");

        do_read(32'hABCD_EF10, rd, 2);
        check("read_reset_value", rd, 32'h0000_0000);

        do_write(32'hFFFF_FFFF, 32'h1234_5678, 0, 1, 0);
        do_read(32'h0000_003C, rd, 0);
        check("read_wrap_index15", rd, 32'h1234_5678);

        do_write(32'h0000_0008, 32'hCAFE_F00D, 1, 0, 5);
        do_read(32'h0000_0008, rd, 1);
        check("read_w_before_aw", rd, 32'hCAFE_F00D);

        // Same-edge write commit and read of index 3.
        do_write(32'h0000_000C, 32'h1111_1111, 0, 0, 0);
        bus.aw_addr = 32'h0000_000C; bus.w_data = 32'h2222_2222; bus.ar_addr = 32'h0000_000C;
        bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
        step();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        model[3] = 32'h2222_2222;
        check("collision_bvalid", 32'(bus.bvalid), 32'd1);
        check("collision_rvalid", 32'(bus.rvalid), 32'd1);
        check("collision_old_data", bus.r_data, 32'h1111_1111);
        bus.bready = 1; bus.rready = 1;
        step();
        bus.bready = 0; bus.rready = 0;
        check("collision_bvalid_clr", 32'(bus.bvalid), 32'd0);
        check("collision_rvalid_clr", 32'(bus.rvalid), 32'd0);
        do_read(32'h0000_000C, rd, 0);
        check("collision_new_data", rd, 32'h2222_2222);

        for (int i = 0; i < 6; i++) begin
            do_write(tbl[i].waddr, tbl[i].wdata, i % 3, (i + 1) % 3, i % 2);
            do_read(tbl[i].raddr, rd, i % 2);
            check($sformatf("table_%0d", i), rd, tbl[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                do_write(ra, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                do_read(ra, rd, $urandom_range(0, 2));
                check($sformatf("random_read_%0d", i), rd, model[widx(ra)]);
            end
        end

        // Reset with a half-collected write and an un-acknowledged read in flight.
        do_write(32'h0000_0014, 32'h7777_7777, 0, 0, 0);
        bus.aw_addr = 32'h0000_0018; bus.awvalid = 1;
        step();
        bus.awvalid = 0;
        check("aw_captured_awready", 32'(bus.awready), 32'd0);
        bus.ar_addr = 32'h0000_0014; bus.arvalid = 1;
        step();
        bus.arvalid = 0;
        check("inflight_rvalid", 32'(bus.rvalid), 32'd1);
        check("inflight_r_data", bus.r_data, 32'h7777_7777);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        #2;
        rst_n = 1'b1;
        step();
        bus.w_data = 32'h0000_0099; bus.wvalid = 1;
        step();
        bus.wvalid = 0;
        check("lone_w_captured", 32'(bus.wready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("lone_w_no_bvalid", 32'(bus.bvalid), 32'd0);
        end
        do_read(32'h0000_0014, rd, 0);
        check("reg_cleared_by_reset", rd, model[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
